// File: rtl/ov5640_sccb_arb.sv
// ov5640_sccb_arb: arbitrates three register-write requesters onto one SCCB engine.
// The config sequencer has strict priority. Runtime and VCM requesters alternate
// round-robin and are enabled by cfg_done. Each write is followed by a fixed gap.
// Optional macro OV5640_ARB_STATS_EN adds saturating tx_cnt/to_cnt outputs.
module ov5640_sccb_arb #(
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned TIMEOUT_MAX = 1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  input  logic        cfg_done,
  output logic        cfg_end,
  output logic        cfg_err,
  input  logic        rt_req,
  input  logic [23:0] rt_data,
  output logic        rt_ack,
  output logic        rt_err,
  input  logic        vcm_req,
  input  logic [23:0] vcm_data,
  output logic        vcm_ack,
  output logic        vcm_err,
  output logic        sccb_start,
  output logic [23:0] sccb_data,
  input  logic        sccb_end,
  output logic        busy
`ifdef OV5640_ARB_STATS_EN
  ,
  output logic [15:0] tx_cnt,
  output logic [15:0] to_cnt
`endif
);

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;
  typedef enum logic [1:0] {OWN_CFG, OWN_RT, OWN_VCM} owner_t;

  state_t           r_state, w_state_nxt;
  owner_t           r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [23:0]      r_sccb_data, w_data_nxt;
  logic             r_cfg_pend;
  logic [23:0]      r_cfg_word;
  logic             r_rr_last, w_rr_nxt;   // 1: VCM was served last, 0: RT
  logic             w_grant_cfg;
  logic             w_done_ok;
  logic             w_done_to;
  logic             r_sccb_start, r_busy;
  logic             r_cfg_end, r_cfg_err;
  logic             r_rt_ack, r_rt_err, r_vcm_ack, r_vcm_err;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state, grant and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_data_nxt  = r_sccb_data;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_last;
    w_grant_cfg = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_cfg_pend || cfg_start) begin
          w_grant_cfg = 1'b1;
          w_owner_nxt = OWN_CFG;
          w_data_nxt  = r_cfg_pend ? r_cfg_word : cfg_data;
          w_state_nxt = S_ISSUE;
        end else if (cfg_done && rt_req && (!vcm_req || r_rr_last)) begin
          w_owner_nxt = OWN_RT;
          w_data_nxt  = rt_data;
          w_state_nxt = S_ISSUE;
        end else if (cfg_done && vcm_req) begin
          w_owner_nxt = OWN_VCM;
          w_data_nxt  = vcm_data;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Success wins over a simultaneous timeout
        if (sccb_end) begin
          w_done_ok   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else if (r_cnt + CNT_W'(1) >= TO_LAST) begin
          w_done_to   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt >= GAP_LAST) begin
          w_state_nxt = S_IDLE;
          if (r_owner != OWN_CFG) w_rr_nxt = (r_owner == OWN_VCM);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers, pending config capture and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_owner      <= OWN_CFG;
      r_cnt        <= '0;
      r_sccb_data  <= '0;
      r_cfg_pend   <= 1'b0;
      r_cfg_word   <= '0;
      r_rr_last    <= 1'b1;
      r_sccb_start <= 1'b0;
      r_busy       <= 1'b0;
      r_cfg_end    <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_rt_ack     <= 1'b0;
      r_rt_err     <= 1'b0;
      r_vcm_ack    <= 1'b0;
      r_vcm_err    <= 1'b0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sccb_data  <= w_data_nxt;
      r_rr_last    <= w_rr_nxt;
      if (w_grant_cfg)                  r_cfg_pend <= 1'b0;
      else if (cfg_start)               r_cfg_pend <= 1'b1;
      if (cfg_start && !r_cfg_pend)     r_cfg_word <= cfg_data;
      r_sccb_start <= (w_state_nxt == S_ISSUE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_cfg_end    <= (w_done_ok || w_done_to) && (r_owner == OWN_CFG);
      r_cfg_err    <= r_cfg_err || (w_done_to && (r_owner == OWN_CFG));
      r_rt_ack     <= w_done_ok && (r_owner == OWN_RT);
      r_rt_err     <= w_done_to && (r_owner == OWN_RT);
      r_vcm_ack    <= w_done_ok && (r_owner == OWN_VCM);
      r_vcm_err    <= w_done_to && (r_owner == OWN_VCM);
    end
  end

  assign sccb_start = r_sccb_start;
  assign sccb_data  = r_sccb_data;
  assign busy       = r_busy;
  assign cfg_end    = r_cfg_end;
  assign cfg_err    = r_cfg_err;
  assign rt_ack     = r_rt_ack;
  assign rt_err     = r_rt_err;
  assign vcm_ack    = r_vcm_ack;
  assign vcm_err    = r_vcm_err;

`ifdef OV5640_ARB_STATS_EN
  logic [15:0] r_tx_cnt, r_to_cnt;

  // Saturating transaction and timeout counters
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_tx_cnt <= '0;
      r_to_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_state_nxt == S_ISSUE && r_tx_cnt != 16'hFFFF)
        r_tx_cnt <= r_tx_cnt + 16'd1;
      if (w_done_to && r_to_cnt != 16'hFFFF)
        r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign tx_cnt = r_tx_cnt;
  assign to_cnt = r_to_cnt;
`endif

endmodule

// File: doc/ov5640_sccb_arb.md
Name: ov5640_sccb_arb

Overview:
Arbiter and sequencer for the single SCCB register-write engine that configures the OV5640.
- Three requesters share the engine:
  - the boot-time register-table sequencer (cfg_*), which has strict priority;
  - the runtime exposure/gain controller (rt_*);
  - the VCM/focus controller (vcm_*).
- The block issues one 24-bit {REG_ADDR[15:0], REG_VAL[7:0]} write at a time and waits for the engine's end pulse or a timeout.
- It then enforces an inter-transaction gap and routes the completion back to the owning requester.

Parameters:
GAP_CYCLES, 16, idle cycles in GAP state after each transaction (min 1).
TIMEOUT_MAX, 1000000, sys_clk cycles allowed in WAIT before abort; counter is 20 bits wide.

Ports:
sys_clk  in  1  system clock (same clock as SCCB engine)
sys_rst  in  1  synchronous reset, active-high
cfg_start  in  1  one-cycle pulse from the config sequencer: write cfg_data
cfg_data  in  24  config write word; sampled only on the cycle cfg_start is high
cfg_done  in  1  level: config table complete; enables runtime requesters
cfg_end  out  1  one-cycle pulse: config write finished (normal or timeout)
cfg_err  out  1  sticky: a config write timed out; cleared only by reset
rt_req  in  1  level request; rt_data held stable until rt_ack or rt_err
rt_data  in  24  runtime write word
rt_ack  out  1  one-cycle pulse: runtime write completed
rt_err  out  1  one-cycle pulse: runtime write timed out
vcm_req  in  1  level request; same rules as rt_req
vcm_data  in  24  VCM write word
vcm_ack  out  1  one-cycle pulse: VCM write completed
vcm_err  out  1  one-cycle pulse: VCM write timed out
sccb_start  out  1  one-cycle pulse to the SCCB engine
sccb_data  out  24  word to the engine; stable from ISSUE through end of WAIT
sccb_end  in  1  one-cycle pulse from the engine: write complete
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state=IDLE; cfg_pend=0; cfg_word=0; rr_last=VCM (so rt wins the first tie); counters 0.
- cfg_start capture: a cfg_start pulse sets cfg_pend and latches cfg_word=cfg_data in any state. A second cfg_start while cfg_pend=1 is ignored (protocol violation).
- States:
  - IDLE: compute grant from (cfg_pend | cfg_start), rt_req and vcm_req. cfg has priority. rt/vcm are eligible only when cfg_done=1; between them, round-robin against rr_last. On any grant: latch owner and word into sccb_data, clear cfg_pend if cfg is the owner, go to ISSUE. With no eligible request, stay in IDLE.
  - ISSUE: exactly 1 cycle, sccb_start=1. Next state WAIT; timeout counter cleared.
  - WAIT: counter increments each cycle.
    - sccb_end=1: go to GAP and pulse the owner's ack (cfg_end/rt_ack/vcm_ack) in the first GAP cycle.
    - Counter reaches TIMEOUT_MAX-1 without sccb_end: go to GAP and pulse the owner's err. A cfg owner gets cfg_end pulse plus cfg_err set, so the sequencer still advances.
    - sccb_end and timeout in the same cycle: treated as success.
  - GAP: hold GAP_CYCLES cycles, then return to IDLE; rr_last is updated to the owner if the owner was rt or vcm.
- Latency: a request sampled in IDLE in cycle k gives sccb_start high in cycle k+1. Ack follows 1 cycle after sccb_end. Minimum request-to-request spacing is 3+GAP_CYCLES cycles.
- Requester and engine rules:
  - sccb_end outside WAIT is ignored.
  - rt_req/vcm_req deasserted before grant: the request is dropped silently. Deasserted after grant: the transaction completes and the ack is still pulsed.
  - cfg_done falling while rt/vcm is pending: those requests are no longer granted.
- sys_rst mid-transaction: immediate return to IDLE on the next edge. No ack/err is emitted and cfg_pend is cleared. The SCCB engine is reset by the same sys_rst.

Optional Feature:
OV5640_ARB_STATS_EN
- Defined: adds output ports tx_cnt[15:0] and to_cnt[15:0].
  - tx_cnt counts transactions entering ISSUE.
  - to_cnt counts timeouts.
  - Both saturate at 16'hFFFF and clear on sys_rst.
- Undefined: no ports, no counter logic; all other behaviour is identical.

Test Plan:
- Config burst: cfg_done=0, drive cfg_start with 24'h310311. Engine returns sccb_end 50 cycles after sccb_start. Required: sccb_start 1 cycle after cfg_start, sccb_data=24'h310311, cfg_end 1 cycle after sccb_end, busy low after 16 GAP cycles.
- Runtime blocked: cfg_done=0, rt_req=1 with rt_data=24'h350000. Required: no sccb_start for 1000 cycles. Raise cfg_done: sccb_start next cycle with 24'h350000, then rt_ack.
- Round-robin: cfg_done=1, rt_req and vcm_req both held high. Required: grants alternate rt, vcm, rt, vcm starting with rt; cfg_start injected mid-WAIT is served next, ahead of both.
- Timeout: TIMEOUT_MAX=100, engine never pulses sccb_end on a config write. Required: cfg_end and cfg_err=1 exactly 100 cycles after ISSUE; the subsequent config write proceeds normally with cfg_err staying 1.
- Reset mid-WAIT: assert sys_rst during a vcm write. Required: busy=0, no vcm_ack/vcm_err, cfg_pend cleared, sccb_start=0 from the next edge.
- Stats (macro defined): 5 successful writes plus 1 timeout. Required: tx_cnt=6, to_cnt=1.
